// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin two-port request front-end for the SDRAM controller.
// One request outstanding at a time; request fields are held for the whole transaction
// and controller completion levels are turned into one-cycle per-port done pulses.
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to abort requests stuck in WAIT.
module sdram_port_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        p0_valid,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wmask,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_valid,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wmask,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [23:0] mem_address,
    output logic        mem_req_read,
    output logic        mem_req_write,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_write_mask,
    input  logic [31:0] mem_data_out,
    input  logic        mem_data_valid,
    input  logic        mem_write_complete
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        state, state_d;
    logic          last_grant, last_grant_d;
    logic          sel, sel_d;
    logic          is_wr, is_wr_d;
    logic [AW-1:0] mem_address_d;
    logic [DW-1:0] mem_data_in_d;
    logic [MW-1:0] mem_write_mask_d;
    logic          mem_req_read_d, mem_req_write_d;
    logic          p0_done_d, p1_done_d, p0_err_d, p1_err_d;
    logic [DW-1:0] p0_rdata_d, p1_rdata_d;
    logic          gnt_c, gnt_we_c, cpl_c;

    // Port 1 wins only when port 0 is idle or port 0 was served last.
    assign gnt_c    = p1_valid & (~p0_valid | ~last_grant);
    assign gnt_we_c = gnt_c ? p1_we : p0_we;
    // Only the completion level matching the transaction type counts.
    assign cpl_c    = is_wr ? mem_write_complete : mem_data_valid;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic          tmo_hit_c;
    assign tmo_hit_c = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT, ERR_DATA};
`endif

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_d          = state;
        last_grant_d     = last_grant;
        sel_d            = sel;
        is_wr_d          = is_wr;
        mem_address_d    = mem_address;
        mem_data_in_d    = mem_data_in;
        mem_write_mask_d = mem_write_mask;
        mem_req_read_d   = 1'b0;
        mem_req_write_d  = 1'b0;
        p0_done_d        = 1'b0;
        p1_done_d        = 1'b0;
        p0_err_d         = 1'b0;
        p1_err_d         = 1'b0;
        p0_rdata_d       = p0_rdata;
        p1_rdata_d       = p1_rdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
        tmo_cnt_d        = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    sel_d            = gnt_c;
                    last_grant_d     = gnt_c;
                    is_wr_d          = gnt_we_c;
                    mem_address_d    = gnt_c ? p1_addr : p0_addr;
                    mem_data_in_d    = gnt_c ? p1_wdata : p0_wdata;
                    mem_write_mask_d = gnt_c ? p1_wmask : p0_wmask;
                    // Request pulse is high for exactly the REQ cycle.
                    mem_req_write_d  = gnt_we_c;
                    mem_req_read_d   = ~gnt_we_c;
                    state_d          = REQ;
                end
            end
            REQ: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (cpl_c) begin
                    if (sel) begin
                        p1_done_d = 1'b1;
                        if (!is_wr) p1_rdata_d = mem_data_out;
                    end else begin
                        p0_done_d = 1'b1;
                        if (!is_wr) p0_rdata_d = mem_data_out;
                    end
                    state_d = DRAIN;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    if (sel) begin
                        p1_done_d = 1'b1;
                        p1_err_d  = 1'b1;
                        if (!is_wr) p1_rdata_d = ERR_DATA;
                    end else begin
                        p0_done_d = 1'b1;
                        p0_err_d  = 1'b1;
                        if (!is_wr) p0_rdata_d = ERR_DATA;
                    end
                    state_d = DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
`endif
            end
            DRAIN: begin
                // A stale completion level must not finish the next request.
                if (!mem_data_valid && !mem_write_complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            sel            <= 1'b0;
            is_wr          <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
            mem_write_mask <= '0;
            mem_req_read   <= 1'b0;
            mem_req_write  <= 1'b0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
            p0_err         <= 1'b0;
            p1_err         <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            state          <= state_d;
            last_grant     <= last_grant_d;
            sel            <= sel_d;
            is_wr          <= is_wr_d;
            mem_address    <= mem_address_d;
            mem_data_in    <= mem_data_in_d;
            mem_write_mask <= mem_write_mask_d;
            mem_req_read   <= mem_req_read_d;
            mem_req_write  <= mem_req_write_d;
            p0_done        <= p0_done_d;
            p1_done        <= p1_done_d;
            p0_err         <= p0_err_d;
            p1_err         <= p1_err_d;
            p0_rdata       <= p0_rdata_d;
            p1_rdata       <= p1_rdata_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt        <= tmo_cnt_d;
`endif
        end
    end

endmodule
